// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier.
// Holds the FSM state encoding and the width rule for the cycle counter.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter must be able to hold Q_WIDTH itself.
   function automatic int count_width(input int q_width);
      return $clog2(q_width + 1);
   endfunction

endpackage

// File: rtl/mult_row.sv
// One row of an array multiplier: the AND partial product of m_i and q_bit_i
// is added to acc_i through a ripple-carry chain.
module mult_row #(
   parameter int M_WIDTH = 3
) (
   input  logic [M_WIDTH-1:0] m_i,
   input  logic               q_bit_i,
   input  logic [M_WIDTH-1:0] acc_i,
   input  logic               cin_i,
   output logic [M_WIDTH-1:0] sum_o,
   output logic               cout_o
);

   logic carry;
   logic pp;

   always_comb begin
      sum_o = '0;
      carry = cin_i;
      pp    = 1'b0;
      for (int i = 0; i < M_WIDTH; i++) begin
         pp       = m_i[i] & q_bit_i;
         sum_o[i] = acc_i[i] ^ pp ^ carry;
         carry    = (acc_i[i] & pp) | (carry & (acc_i[i] ^ pp));
      end
      cout_o = carry;
   end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one reused multiplier row, one multiplier
// bit per clock, valid/ready handshakes on both the operand and product side.
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int M_WIDTH = 3,
   parameter int Q_WIDTH = 2,
   parameter int P_WIDTH = M_WIDTH + Q_WIDTH
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [M_WIDTH-1:0] min,
   input  logic [Q_WIDTH-1:0] qin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [P_WIDTH-1:0] product
);

   localparam int             CW   = count_width(Q_WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(Q_WIDTH - 1);

   state_t             state_q, state_d;
   logic [M_WIDTH-1:0] m_q, m_d;
   logic [Q_WIDTH-1:0] q_q, q_d;
   logic [P_WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      count_q, count_d;

   logic [M_WIDTH-1:0] row_sum;
   logic               row_cout;
   logic [P_WIDTH-1:0] acc_step;
   logic               accept;

   mult_row #(.M_WIDTH(M_WIDTH)) u_row (
      .m_i     (m_q),
      .q_bit_i (q_q[0]),
      .acc_i   (acc_q[P_WIDTH-1:Q_WIDTH]),
      .cin_i   (1'b0),
      .sum_o   (row_sum),
      .cout_o  (row_cout)
   );

   // Row result lands in the top bits; the low part shifts right by one.
   generate
      if (Q_WIDTH == 1) begin : g_q1
         assign acc_step = {row_cout, row_sum};
      end else begin : g_qn
         assign acc_step = {row_cout, row_sum, acc_q[Q_WIDTH-1:1]};
      end
   endgenerate

   assign in_ready  = reset_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == DONE);
   assign product   = acc_q;

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      q_d     = q_q;
      acc_d   = acc_q;
      count_d = count_q;
      if (accept) begin
         // Covers both IDLE and the same-edge retire-and-reload from DONE.
         m_d     = min;
         q_d     = qin;
         acc_d   = '0;
         count_d = '0;
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               acc_d   = acc_step;
               q_d     = q_q >> 1;
               count_d = count_q + 1'b1;
               if (count_q == LAST) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            IDLE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         q_q     <= '0;
         acc_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         q_q     <= q_d;
         acc_q   <= acc_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: default 3x2 instance plus an 8x8 instance,
// with scoreboard queues popped whenever a product handshake completes.
module tb_shift_add_multiplier;

   logic clk;
   logic rst_n;

   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic [2:0]  min_a;
   logic [1:0]  qin_a;
   logic [4:0]  product_a;

   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic [7:0]  min_b;
   logic [7:0]  qin_b;
   logic [15:0] product_b;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_a[$];
   int exp_b[$];

   shift_add_multiplier u_dut_a (
      .clock     (clk),
      .reset_n   (rst_n),
      .in_valid  (in_valid_a),
      .in_ready  (in_ready_a),
      .min       (min_a),
      .qin       (qin_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready_a),
      .product   (product_a)
   );

   shift_add_multiplier #(.M_WIDTH(8), .Q_WIDTH(8)) u_dut_b (
      .clock     (clk),
      .reset_n   (rst_n),
      .in_valid  (in_valid_b),
      .in_ready  (in_ready_b),
      .min       (min_b),
      .qin       (qin_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b),
      .product   (product_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   // Scoreboard monitors: one comparison per retired product.
   always @(negedge clk) begin
      if (rst_n && out_valid_a && out_ready_a) begin
         if (exp_a.size() == 0) begin
            check("unexpected_a", 32'(product_a), 32'hFFFF_FFFF);
         end else begin
            int e;
            e = exp_a.pop_front();
            $display("txn A: product=%0d expected=%0d", product_a, e);
            check("product_a", 32'(product_a), 32'(e));
         end
      end
      if (rst_n && out_valid_b && out_ready_b) begin
         if (exp_b.size() == 0) begin
            check("unexpected_b", 32'(product_b), 32'hFFFF_FFFF);
         end else begin
            int e;
            e = exp_b.pop_front();
            $display("txn B: product=%0d expected=%0d", product_b, e);
            check("product_b", 32'(product_b), 32'(e));
         end
      end
   end

   task automatic op_a(input int m, input int q, input bit push);
      int waited;
      waited = 0;
      @(posedge clk); #1;
      while (!in_ready_a && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready_a) begin
         check("op_a_ready_timeout", 32'd0, 32'd1);
         return;
      end
      min_a = m[2:0];
      qin_a = q[1:0];
      in_valid_a = 1'b1;
      if (push) exp_a.push_back(m * q);
      @(posedge clk); #1;
      in_valid_a = 1'b0;
   endtask

   task automatic op_b(input int m, input int q);
      int waited;
      waited = 0;
      @(posedge clk); #1;
      while (!in_ready_b && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready_b) begin
         check("op_b_ready_timeout", 32'd0, 32'd1);
         return;
      end
      min_b = m[7:0];
      qin_b = q[7:0];
      in_valid_b = 1'b1;
      exp_b.push_back(m * q);
      @(posedge clk); #1;
      in_valid_b = 1'b0;
   endtask

   task automatic drain_a();
      int n;
      n = 0;
      while (exp_a.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain_a", 32'(exp_a.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic drain_b();
      int n;
      n = 0;
      while (exp_b.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain_b", 32'(exp_b.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic wait_valid_a(input string tag);
      int n;
      n = 0;
      while (!out_valid_a && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(out_valid_a), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      in_valid_a = 1'b0; min_a = '0; qin_a = '0; out_ready_a = 1'b1;
      in_valid_b = 1'b0; min_b = '0; qin_b = '0; out_ready_b = 1'b1;

      // Reset state
      #2;
      check("rst_in_ready_a", 32'(in_ready_a), 32'd0);
      check("rst_out_valid_a", 32'(out_valid_a), 32'd0);
      check("rst_product_a", 32'(product_a), 32'd0);
      check("rst_in_ready_b", 32'(in_ready_b), 32'd0);
      #10;
      rst_n = 1'b1;
      #1;
      check("idle_in_ready_a", 32'(in_ready_a), 32'd1);

      // 7*3 with exact latency
      op_a(7, 3, 1'b1);
      @(negedge clk);
      check("run_in_ready_a", 32'(in_ready_a), 32'd0);
      check("run_out_valid_a_c0", 32'(out_valid_a), 32'd0);
      @(negedge clk);
      check("run_out_valid_a_c1", 32'(out_valid_a), 32'd0);
      @(negedge clk);
      check("lat_out_valid_a", 32'(out_valid_a), 32'd1);
      check("lat_product_a", 32'(product_a), 32'd21);
      drain_a();

      // Every operand pair, including the zero rows and columns
      for (int m = 0; m < 8; m++) begin
         for (int q = 0; q < 4; q++) begin
            op_a(m, q, 1'b1);
         end
      end
      drain_a();

      // Backpressure: result held, new operands ignored
      out_ready_a = 1'b0;
      op_a(5, 2, 1'b1);
      wait_valid_a("bp_wait_valid");
      @(posedge clk); #1;
      in_valid_a = 1'b1; min_a = 3'd1; qin_a = 2'd1;
      repeat (6) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid_a), 32'd1);
         check("bp_product", 32'(product_a), 32'd10);
         check("bp_in_ready", 32'(in_ready_a), 32'd0);
      end
      @(posedge clk); #1;
      in_valid_a = 1'b0;
      out_ready_a = 1'b1;
      @(negedge clk);
      check("bp_release_valid", 32'(out_valid_a), 32'd1);
      @(posedge clk); #1;
      check("bp_valid_falls", 32'(out_valid_a), 32'd0);
      check("bp_queue_empty", 32'(exp_a.size()), 32'd0);

      // Back-to-back: retire 21 and accept 2*3 on the same edge
      out_ready_a = 1'b0;
      op_a(7, 3, 1'b1);
      wait_valid_a("b2b_wait_valid");
      @(posedge clk); #1;
      check("b2b_product_held", 32'(product_a), 32'd21);
      out_ready_a = 1'b1;
      in_valid_a = 1'b1; min_a = 3'd2; qin_a = 2'd3;
      exp_a.push_back(6);
      #1;
      check("b2b_in_ready", 32'(in_ready_a), 32'd1);
      @(posedge clk); #1;
      in_valid_a = 1'b0;
      check("b2b_run_valid", 32'(out_valid_a), 32'd0);
      @(posedge clk);
      @(posedge clk); #1;
      check("b2b_out_valid", 32'(out_valid_a), 32'd1);
      check("b2b_product", 32'(product_a), 32'd6);
      drain_a();

      // Reset mid-RUN aborts without a clock edge
      op_a(6, 3, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid_a), 32'd0);
      check("abort_product", 32'(product_a), 32'd0);
      check("abort_in_ready", 32'(in_ready_a), 32'd0);
      #20;
      rst_n = 1'b1;
      #1;
      check("abort_idle_ready", 32'(in_ready_a), 32'd1);
      op_a(3, 2, 1'b1);
      drain_a();

      // 8x8 instance: full-scale operands and latency
      op_b(255, 255);
      repeat (7) @(posedge clk);
      #1;
      check("b_valid_early", 32'(out_valid_b), 32'd0);
      @(posedge clk); #1;
      check("b_valid_lat", 32'(out_valid_b), 32'd1);
      check("b_product_max", 32'(product_b), 32'd65025);
      drain_b();
      op_b(128, 1);
      drain_b();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
